// File: rtl/dmem_arbiter.sv
// Data-memory port controller: arbitrates the MEM stage and a debug/loader requester
// onto one variable-latency memory port, stalls the CPU while busy, and times out hung accesses.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_owner;
  owner_t           grant_c;
  logic [CNT_W-1:0] cnt;
  logic             done_c;
  logic [31:0]      rd_val_c;

  // On a tie the requester that lost the previous grant wins.
  always_comb begin
    grant_c = OWN_CPU;
    if (cpu_req && dbg_req) begin
      grant_c = (last_owner == OWN_DBG) ? OWN_CPU : OWN_DBG;
    end else if (!cpu_req) begin
      grant_c = OWN_DBG;
    end
  end

  // An access ends on mem_ready, or on the last allowed BUSY cycle without it.
  assign done_c   = mem_ready || (cnt == CNT_LAST);
  assign rd_val_c = mem_ready ? mem_rdata : TIMEOUT_DATA;

  assign cpu_stall = cpu_req & ~((state == RESP) && (owner == OWN_CPU));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DBG;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      dbg_ack    <= 1'b0;
      err        <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            owner      <= grant_c;
            last_owner <= grant_c;
            cnt        <= '0;
            mem_en     <= 1'b1;
            state      <= BUSY;
            if (grant_c == OWN_CPU) begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end else begin
              mem_we    <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
            end
          end
        end
        BUSY: begin
          if (done_c) begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            dbg_ack <= (owner == OWN_DBG);
            state   <= RESP;
            if (!mem_ready) begin
              err <= 1'b1;
            end
            if (!mem_we) begin
              if (owner == OWN_CPU) begin
                cpu_rdata <= rd_val_c;
              end else begin
                dbg_rdata <= rd_val_c;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, dbg_ack, mem_en, mem_we, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1;
    #2;
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en got %0b exp 0", mem_en); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %0b exp 0", mem_we); end
    n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
    n_vec++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h/%h exp 0/0", cpu_rdata, dbg_rdata); end
    n_vec++; if (dbg_ack !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_ack_err got %0b/%0b exp 0/0", dbg_ack, err); end
    n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_hi got %0b exp 1", cpu_stall); end
    cpu_req = 1'b0;
    #1;
    n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_lo got %0b exp 0", cpu_stall); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_cpu_load();
    next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; settle();
    n_vec++; if (mem_en !== 1'b0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL load_idle en/stall got %0b/%0b exp 0/1", mem_en, cpu_stall); end
    next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h1234_5678; settle();
    n_vec++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin n_err++; $display("FAIL load_busy en/we/addr got %0b/%0b/%h exp 1/0/00000040", mem_en, mem_we, mem_addr); end
    n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL load_busy_stall got %0b exp 1", cpu_stall); end
    next_cycle(); mem_ready = 1'b0; mem_rdata = 32'h0; settle();
    n_vec++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL load_resp en/stall got %0b/%0b exp 0/0", mem_en, cpu_stall); end
    n_vec++; if (cpu_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL load_rdata got %h exp 12345678", cpu_rdata); end
    n_vec++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL load_dbg_ack got %0b exp 0", dbg_ack); end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_store();
    next_cycle(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hA5A5_A5A5; settle();
    n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL store_idle_stall got %0b exp 1", cpu_stall); end
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); mem_ready = (k == 3); mem_rdata = 32'hFFFF_0000; settle();
      n_vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hA5A5_A5A5) begin
        n_err++; $display("FAIL store_busy%0d en/we/addr/wd got %0b/%0b/%h/%h exp 1/1/00000080/a5a5a5a5", k, mem_en, mem_we, mem_addr, mem_wdata); end
      n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL store_busy%0d_stall got %0b exp 1", k, cpu_stall); end
    end
    next_cycle(); mem_ready = 1'b0; settle();
    n_vec++; if (cpu_stall !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL store_resp stall/en got %0b/%0b exp 0/0", cpu_stall, mem_en); end
    n_vec++; if (cpu_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL store_rdata_held got %h exp 12345678", cpu_rdata); end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic exp_dbg;
    logic [31:0] exp_addr;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_dbg  = (i % 2) == 1;
      exp_addr = exp_dbg ? 32'h200 : 32'h100;
      next_cycle(); cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
      cpu_addr = 32'h100; dbg_addr = 32'h200; settle();
      n_vec++; if (cpu_stall !== 1'b1 || dbg_ack !== 1'b0) begin n_err++; $display("FAIL tie%0d_idle stall/ack got %0b/%0b exp 1/0", i, cpu_stall, dbg_ack); end
      next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(i); settle();
      n_vec++; if (mem_addr !== exp_addr) begin n_err++; $display("FAIL tie%0d_grant addr got %h exp %h", i, mem_addr, exp_addr); end
      next_cycle(); mem_ready = 1'b0; settle();
      n_vec++; if (dbg_ack !== exp_dbg || cpu_stall !== exp_dbg) begin n_err++; $display("FAIL tie%0d_resp ack/stall got %0b/%0b exp %0b/%0b", i, dbg_ack, cpu_stall, exp_dbg, exp_dbg); end
      n_vec++; if ((exp_dbg ? dbg_rdata : cpu_rdata) !== 32'h1000 + 32'(i)) begin n_err++; $display("FAIL tie%0d_rdata got %h/%h exp %h", i, cpu_rdata, dbg_rdata, 32'h1000 + 32'(i)); end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
  endtask

  task automatic test_timeout();
    next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; mem_ready = 1'b0; settle();
    for (int k = 1; k <= int'(TO); k++) begin
      next_cycle(); settle();
      n_vec++; if (mem_en !== 1'b1 || err !== 1'b0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL to_busy%0d en/err/stall got %0b/%0b/%0b exp 1/0/1", k, mem_en, err, cpu_stall); end
    end
    next_cycle(); settle();
    n_vec++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL to_resp en/stall got %0b/%0b exp 0/0", mem_en, cpu_stall); end
    n_vec++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL to_rdata got %h exp deadbeef", cpu_rdata); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err got %0b exp 1", err); end
    cpu_req = 1'b0;
    for (int k = 0; k < 20; k++) next_cycle();
    settle();
    n_vec++; if (err !== 1'b1 || mem_en !== 1'b0) begin n_err++; $display("FAIL to_err_sticky err/en got %0b/%0b exp 1/0", err, mem_en); end
  endtask

  task automatic test_reset_mid_busy();
    next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h48; settle();
    next_cycle(); settle();
    n_vec++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL rmb_busy1_en got %0b exp 1", mem_en); end
    next_cycle(); rst = 1'b1; settle();
    n_vec++; if (mem_en !== 1'b0 || err !== 1'b0 || mem_addr !== 32'h0) begin n_err++; $display("FAIL rmb_async en/err/addr got %0b/%0b/%h exp 0/0/0", mem_en, err, mem_addr); end
    n_vec++; if (cpu_rdata !== 32'h0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL rmb_async rdata/stall got %h/%0b exp 0/1", cpu_rdata, cpu_stall); end
    next_cycle(); rst = 1'b0; settle();
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rmb_idle_en got %0b exp 0", mem_en); end
    next_cycle(); mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; settle();
    n_vec++; if (mem_en !== 1'b1 || mem_addr !== 32'h48) begin n_err++; $display("FAIL rmb_regrant en/addr got %0b/%h exp 1/00000048", mem_en, mem_addr); end
    next_cycle(); mem_ready = 1'b0; settle();
    n_vec++; if (cpu_rdata !== 32'hCAFE_F00D || cpu_stall !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rmb_resp rdata/stall/err got %h/%0b/%0b exp cafef00d/0/0", cpu_rdata, cpu_stall, err); end
    cpu_req = 1'b0;
  endtask

  task automatic test_flush();
    next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4C; settle();
    next_cycle(); settle();
    n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL flush_busy1_stall got %0b exp 1", cpu_stall); end
    next_cycle(); cpu_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D; settle();
    n_vec++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1) begin n_err++; $display("FAIL flush_busy2 stall/en got %0b/%0b exp 0/1", cpu_stall, mem_en); end
    next_cycle(); mem_ready = 1'b0; settle();
    n_vec++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL flush_resp en/stall/rdata got %0b/%0b/%h exp 0/0/0badf00d", mem_en, cpu_stall, cpu_rdata); end
    next_cycle(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h55; settle();
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL flush_next_idle_en got %0b exp 0", mem_en); end
    next_cycle(); mem_ready = 1'b1; settle();
    n_vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h55) begin n_err++; $display("FAIL flush_next_busy en/we/addr/wd got %0b/%0b/%h/%h exp 1/1/10/55", mem_en, mem_we, mem_addr, mem_wdata); end
    next_cycle(); mem_ready = 1'b0; settle();
    n_vec++; if (dbg_ack !== 1'b1) begin n_err++; $display("FAIL flush_next_ack got %0b exp 1", dbg_ack); end
    dbg_req = 1'b0; dbg_we = 1'b0;
    next_cycle(); settle();
    n_vec++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL flush_ack_pulse got %0b exp 0", dbg_ack); end
  endtask

  // Transaction-level model: each access is one grant, a latency, and a result.
  task automatic test_random();
    logic        last_dbg, err_m, cr, dr, win_dbg, exp_we;
    logic [31:0] cpu_rd_m, dbg_rd_m, exp_addr, exp_wd, rd, val;
    int unsigned lat, nb;
    do_reset();
    last_dbg = 1'b1; err_m = 1'b0; cpu_rd_m = '0; dbg_rd_m = '0; rd = '0;
    for (int t = 0; t < 60; t++) begin
      do begin
        cr = 1'($urandom_range(0, 1));
        dr = 1'($urandom_range(0, 1));
      end while (!cr && !dr);
      win_dbg  = (cr && dr) ? !last_dbg : dr;
      last_dbg = win_dbg;
      lat = $urandom_range(1, TO + 1);
      nb  = (lat > TO) ? TO : lat;
      next_cycle();
      cpu_req = cr; dbg_req = dr;
      cpu_we = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
      cpu_addr = $urandom; dbg_addr = $urandom; cpu_wdata = $urandom; dbg_wdata = $urandom;
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      exp_we   = win_dbg ? dbg_we : cpu_we;
      exp_addr = win_dbg ? dbg_addr : cpu_addr;
      exp_wd   = win_dbg ? dbg_wdata : cpu_wdata;
      settle();
      n_vec++; if (mem_en !== 1'b0 || cpu_stall !== cr) begin n_err++; $display("FAIL rnd%0d_idle en/stall got %0b/%0b exp 0/%0b", t, mem_en, cpu_stall, cr); end
      for (int unsigned k = 1; k <= nb; k++) begin
        next_cycle(); mem_ready = (k == lat); mem_rdata = $urandom;
        if (k == lat) rd = mem_rdata;
        settle();
        n_vec++; if (mem_en !== 1'b1 || mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wd || cpu_stall !== cr) begin
          n_err++; $display("FAIL rnd%0d_busy%0d en/we/addr/wd/stall got %0b/%0b/%h/%h/%0b exp 1/%0b/%h/%h/%0b",
                            t, k, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, exp_we, exp_addr, exp_wd, cr); end
      end
      next_cycle(); mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      if (!exp_we) begin
        val = (lat > TO) ? 32'hDEAD_BEEF : rd;
        if (win_dbg) dbg_rd_m = val; else cpu_rd_m = val;
      end
      if (lat > TO) err_m = 1'b1;
      settle();
      n_vec++; if (mem_en !== 1'b0 || dbg_ack !== win_dbg || cpu_stall !== (cr && win_dbg) || err !== err_m) begin
        n_err++; $display("FAIL rnd%0d_resp en/ack/stall/err got %0b/%0b/%0b/%0b exp 0/%0b/%0b/%0b",
                          t, mem_en, dbg_ack, cpu_stall, err, win_dbg, cr && win_dbg, err_m); end
      n_vec++; if (cpu_rdata !== cpu_rd_m || dbg_rdata !== dbg_rd_m) begin
        n_err++; $display("FAIL rnd%0d_rdata cpu/dbg got %h/%h exp %h/%h", t, cpu_rdata, dbg_rdata, cpu_rd_m, dbg_rd_m); end
    end
    cpu_req = 1'b0; dbg_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_simultaneous();
    test_timeout();
    test_reset_mid_busy();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
